// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs bytes into 32-bit LE words, buffers them in a FWFT FIFO
// Optional idle auto-flush of a partial word is enabled by defining PACK_TIMEOUT_FLUSH_EN.
module byte_word_packer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_in,
  input  logic [7:0]                   din,
  input  logic                         flush,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [31:0]                  word_data,
  output logic [2:0]                   word_bytes,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("byte_word_packer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]  cnt;
  logic [31:0] shreg;
  logic [31:0] word_next;
  logic        full_word;
  logic        flush_eff;
  logic        push_req;
  logic [2:0]  push_bytes;
  logic        push_q;
  logic [31:0] push_data_q;
  logic [2:0]  push_bytes_q;

`ifdef PACK_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          tmo_flush;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle with a partial word held.
  assign tmo_flush = !en_in && (cnt != 2'd0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign flush_eff = flush | tmo_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || en_in || cnt == 2'd0 || tmo_flush) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush_eff = flush;
`endif

  always_comb begin
    word_next = shreg;
    if (en_in) begin
      word_next[{cnt, 3'b000} +: 8] = din;
    end
    full_word  = en_in && (cnt == 2'd3);
    push_req   = full_word || (flush_eff && ((cnt != 2'd0) || en_in));
    push_bytes = full_word ? 3'd4 : ({1'b0, cnt} + {2'b00, en_in});
  end

  // Completed words are staged one cycle before entering the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      shreg        <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_bytes_q <= '0;
    end else begin
      push_q <= push_req;
      if (push_req) begin
        push_data_q  <= word_next;
        push_bytes_q <= push_bytes;
        cnt          <= '0;
        shreg        <= '0;
      end else begin
        shreg <= word_next;
        if (en_in) begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

  logic [31:0] mem_data  [FIFO_DEPTH];
  logic [2:0]  mem_bytes [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == DEPTH_L);
  assign word_valid = (level != '0);
  assign pop        = word_valid && word_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en      = push_q && (!full || pop);
  assign word_data  = mem_data[rd_ptr[AW-1:0]];
  assign word_bytes = mem_bytes[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_bytes[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_data[wr_ptr[AW-1:0]]  <= push_data_q;
        mem_bytes[wr_ptr[AW-1:0]] <= push_bytes_q;
        wr_ptr                    <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_q && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Sits directly downstream of the source-select stage and consumes its registered byte stream (enable plus 8-bit data).
- Packs consecutive bytes into 32-bit little-endian words and buffers completed words in a small first-word-fall-through FIFO.
- Presents buffered words to the next stage over a valid/ready handshake.
- Supports an explicit flush of a partial word and reports overflow.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit word entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 64, idle cycles before auto-flush (used only with the optional feature).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en_in  input  1  byte strobe from upstream; one byte accepted per cycle while high.
- din  input  8  byte data, valid when en_in=1.
- flush  input  1  one-cycle pulse: emit the partial word now.
- word_valid  output  1  FIFO head holds a word.
- word_ready  input  1  downstream accepts the head word.
- word_data  output  32  head word; first byte of the word in [7:0].
- word_bytes  output  3  valid byte count of the head word, 1..4.
- level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears the packer count, shift register, FIFO pointers and timeout counter.
- Reset values: word_valid=0, word_data=0, word_bytes=0, level=0, overflow=0.
- Reset mid-operation discards any partial word and all buffered words.
- Packer state is the byte count cnt in 0..3:
  - With en_in=1, din is written into byte lane cnt.
  - If cnt<3, cnt increments.
  - If cnt==3, the full word is pushed with word_bytes=4 and cnt returns to 0.
- Latency: the byte completing a word, sampled on edge N, makes word_valid=1 after edge N+1 when the FIFO was empty.
- Flush (flush=1) with cnt>0 pushes the partial word: unused upper lanes are 0, word_bytes=cnt, then cnt returns to 0.
- Flush with cnt==0 does nothing; no empty words are ever produced.
- Flush and en_in in the same cycle:
  - The byte is accepted first.
  - If that byte completes the word, exactly one word (bytes=4) is pushed.
  - Otherwise the partial word including that byte is pushed with word_bytes=cnt+1.
- At most one push per cycle.
- Pop happens on word_valid && word_ready. word_data and word_bytes show the next entry from the following cycle; they are stable while word_valid=1 and word_ready=0.
- Push while full:
  - If a pop occurs in the same cycle, the push succeeds and level is unchanged.
  - Otherwise the word is dropped, overflow is set to 1 and held until reset, and the packer still returns cnt to 0.
- Push and pop when empty: the word goes into the FIFO; word_valid rises the next cycle, with no bypass.
- level = push count minus pop count, range 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- When word_valid=0: word_data and word_bytes hold their last values and are don't-care to consumers.

Optional Feature:
- Macro: PACK_TIMEOUT_FLUSH_EN.
- Defined:
  - An idle counter resets on every en_in=1 cycle and counts cycles with en_in=0 while cnt>0.
  - When it reaches TIMEOUT_CYCLES, an internal flush is generated that cycle, with behaviour identical to the flush port, and the counter clears.
  - The counter is held at 0 when cnt==0.
- Not defined: no counter exists, and partial words leave only via the flush port.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 -> one cycle after 0x44, word_valid=1, word_data=0x44332211, word_bytes=4; popped next cycle, level back to 0.
- Bytes 0xAA,0xBB, then flush pulse -> word_data=0x0000BBAA, word_bytes=2; flush with cnt==0 -> no word, level unchanged.
- Byte 0xCC with flush in the same cycle after 3 buffered bytes 0x01,0x02,0x03 -> exactly one word 0xCC030201, bytes=4, level=1.
- word_ready=0, stream 4*FIFO_DEPTH+4 bytes -> level=FIFO_DEPTH, overflow=1; first 8 words intact in order; after draining, overflow still 1 until rst_n=0.
- Full FIFO with word_ready=1 while a 4th byte arrives -> push and pop both succeed, level stays FIFO_DEPTH, overflow stays 0.
- With PACK_TIMEOUT_FLUSH_EN and TIMEOUT_CYCLES=64: byte 0x5A then idle -> word 0x0000005A, bytes=1 appears 65-66 cycles later; without the macro no word appears.
